// File: rtl/midi_ctrl_tx.sv
// midi_ctrl_tx: MIDI OUT transmitter for internally generated controller
// messages (pitch bend and control change). A one-cycle request is formatted
// into a 2- or 3-byte MIDI message, with optional running status, and then
// shifted out as 8N1 serial data at BAUD.
//
// Ports:
//   CLOCK_50    system clock
//   reset_data  synchronous reset, active high
//   channel     MIDI channel, latched at accept
//   send_pitch  one-cycle pitch bend request (wins over send_cc)
//   pitch_val   14-bit pitch bend value, 8192 = centre
//   send_cc     one-cycle control change request
//   cc_num      controller number
//   cc_val      controller value
//   busy        high from the cycle after accept until the last stop bit ends
//   done        one-cycle pulse after the final stop bit
//   txd         serial MIDI out, idles high, driven straight from a flop
//
// state | meaning
// IDLE  | line high, waiting for a request
// START | start bit (low) for BIT_DIV clocks
// DATA  | 8 data bits, LSB first, BIT_DIV clocks each
// STOP  | stop bit (high); on exit either loads the next byte and returns to
//       | START (the NEXT_BYTE step, no idle gap) or finishes with done
module midi_ctrl_tx #(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 31250,
  parameter int BIT_DIV        = CLK_HZ / BAUD,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset_data,
  input  logic [3:0]  channel,
  input  logic        send_pitch,
  input  logic [13:0] pitch_val,
  input  logic        send_cc,
  input  logic [6:0]  cc_num,
  input  logic [6:0]  cc_val,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [15:0]     pend;        // bytes still to send, next one in [7:0]
  logic [1:0]      pend_cnt;
  logic [7:0]      last_status; // 0x00 never matches a real status byte

  logic            accept;
  logic            skip_status;
  logic            baud_wrap;
  logic [7:0]      status_n;
  logic [7:0]      byte1_n;
  logic [7:0]      byte2_n;

  always_comb begin
    accept      = (state == IDLE) && !busy && (send_pitch || send_cc);
    status_n    = send_pitch ? {4'hE, channel} : {4'hB, channel};
    byte1_n     = send_pitch ? {1'b0, pitch_val[6:0]} : {1'b0, cc_num};
    byte2_n     = send_pitch ? {1'b0, pitch_val[13:7]} : {1'b0, cc_val};
    skip_status = RUNNING_STATUS && (status_n == last_status);
    baud_wrap   = (baud_cnt == CW'(BIT_DIV - 1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset_data) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      pend        <= '0;
      pend_cnt    <= '0;
      last_status <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      txd         <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          txd      <= 1'b1;
          if (accept) begin
            busy  <= 1'b1;
            txd   <= 1'b0;
            state <= START;
            if (skip_status) begin
              shreg    <= byte1_n;
              pend     <= {8'h00, byte2_n};
              pend_cnt <= 2'd1;
            end else begin
              shreg       <= status_n;
              pend        <= {byte2_n, byte1_n};
              pend_cnt    <= 2'd2;
              last_status <= status_n;
            end
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (pend_cnt != 2'd0) begin
              shreg    <= pend[7:0];
              pend     <= {8'h00, pend[15:8]};
              pend_cnt <= pend_cnt - 1'b1;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
